// File: rtl/conv_acc_sched.sv
// conv_acc_sched: sequences one output tile of the conv_acc partial-sum
// accumulator as a series of channel passes (launch, element stream, drain).
// Optional stall counter: define CONV_ACC_SCHED_PERF_EN to build perf_stall_o;
// otherwise the port is tied to zero.
module conv_acc_sched #(
   parameter int AW        = 8,
   parameter int SW        = 11,
   parameter int PW        = 6,
   parameter int DRAIN_CYC = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cfg_start_i,
   input  logic          cfg_abort_i,
   input  logic [AW-1:0] cfg_base_i,
   input  logic [SW-1:0] cfg_size_i,
   input  logic [PW-1:0] cfg_passes_i,
   input  logic          cfg_fc_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          aborted_o,
   output logic          acc_start_o,
   output logic [AW-1:0] acc_base_o,
   output logic [SW-1:0] acc_size_o,
   output logic          acc_fc_o,
   output logic          acc_first_o,
   output logic          acc_last_o,
   input  logic          acc_ready_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   output logic [PW-1:0] pass_idx_o,
   output logic [31:0]   perf_stall_o
);

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic          busy_q, done_q, aborted_q, acc_start_q, fc_q, first_q, last_q;
   logic [AW-1:0] base_q;
   logic [SW-1:0] size_q, elem_cnt_q;
   logic [PW-1:0] passes_q, pass_idx_q;
   logic [3:0]    drain_cnt_q;
   logic          accept, last_pass, abort_take, start_ok;

   assign in_ready_o = (state_q == S_RUN) & acc_ready_i & (elem_cnt_q < size_q);
   assign accept     = in_valid_i & in_ready_o;
   assign last_pass  = (pass_idx_q == passes_q - 1'b1);
   // Abort only matters while a pass is in flight; in DONE the done pulse already fired.
   assign abort_take = cfg_abort_i &
                       ((state_q == S_LAUNCH) | (state_q == S_RUN) | (state_q == S_DRAIN));
   assign start_ok   = (cfg_size_i != '0) & (cfg_passes_i != '0);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; abort overrides every other transition
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cfg_start_i) state_d = start_ok ? S_LAUNCH : S_DONE;
         S_LAUNCH: state_d = S_RUN;
         S_RUN:    if (accept && (elem_cnt_q == size_q - 1'b1)) state_d = S_DRAIN;
         S_DRAIN:  if (drain_cnt_q == 4'd0) state_d = last_pass ? S_DONE : S_LAUNCH;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (abort_take) state_d = S_IDLE;
   end

   // Registered outputs, latched config and pass/element/drain counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         acc_start_q <= 1'b0;
         fc_q        <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         base_q      <= '0;
         size_q      <= '0;
         passes_q    <= '0;
         pass_idx_q  <= '0;
         elem_cnt_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         busy_q      <= (state_d != S_IDLE);
         done_q      <= (state_d == S_DONE);
         aborted_q   <= abort_take;
         acc_start_q <= (state_d == S_LAUNCH);
         if (state_q == S_IDLE && cfg_start_i && start_ok) begin
            base_q     <= cfg_base_i;
            size_q     <= cfg_size_i;
            passes_q   <= cfg_passes_i;
            fc_q       <= cfg_fc_i;
            pass_idx_q <= '0;
         end
         if (state_q == S_DRAIN && state_d == S_LAUNCH)
            pass_idx_q <= pass_idx_q + 1'b1;
         // first/last are fixed at launch and held until the pass drains
         if (state_d == S_LAUNCH) begin
            if (state_q == S_IDLE) begin
               first_q <= 1'b1;
               last_q  <= (cfg_passes_i == PW'(1));
            end else begin
               first_q <= 1'b0;
               last_q  <= (pass_idx_q + 1'b1 == passes_q - 1'b1);
            end
         end else if (state_d == S_IDLE || state_d == S_DONE) begin
            first_q <= 1'b0;
            last_q  <= 1'b0;
         end
         if (state_d == S_LAUNCH)  elem_cnt_q <= '0;
         else if (accept)          elem_cnt_q <= elem_cnt_q + 1'b1;
         if (state_q == S_RUN && state_d == S_DRAIN)
            drain_cnt_q <= 4'(DRAIN_CYC - 1);
         else if (state_q == S_DRAIN && drain_cnt_q != 4'd0)
            drain_cnt_q <= drain_cnt_q - 4'd1;
      end
   end

`ifdef CONV_ACC_SCHED_PERF_EN
   logic [31:0] perf_q;
   // Saturating count of RUN cycles where an element waits on the accumulator
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         perf_q <= '0;
      else if (state_q == S_IDLE && cfg_start_i)
         perf_q <= '0;
      else if (state_q == S_RUN && in_valid_i && !acc_ready_i && perf_q != 32'hFFFF_FFFF)
         perf_q <= perf_q + 32'd1;
   end
   assign perf_stall_o = perf_q;
`else
   assign perf_stall_o = 32'd0;
`endif

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign aborted_o   = aborted_q;
   assign acc_start_o = acc_start_q;
   assign acc_base_o  = base_q;
   assign acc_size_o  = size_q;
   assign acc_fc_o    = fc_q;
   assign acc_first_o = first_q;
   assign acc_last_o  = last_q;
   assign pass_idx_o  = pass_idx_q;

endmodule

// File: tb/tb_conv_acc_sched.sv
// Self-checking bench for conv_acc_sched: directed scenarios plus random
// backpressure tiles checked against a per-pass schedule model.
module tb_conv_acc_sched;
   localparam int AW = 8, SW = 11, PW = 6, DRAIN = 2, MAXC = 1024;

   logic          clk, rst_n, cfg_start, cfg_abort, cfg_fc, acc_ready, in_valid;
   logic [AW-1:0] cfg_base;
   logic [SW-1:0] cfg_size;
   logic [PW-1:0] cfg_passes;
   logic          busy, done, aborted, acc_start, acc_fc, acc_first, acc_last, in_ready;
   logic [AW-1:0] acc_base;
   logic [SW-1:0] acc_size;
   logic [PW-1:0] pass_idx;
   logic [31:0]   perf_stall;

   int n_chk = 0, n_pass = 0;
   bit rdy[MAXC], e_start[MAXC], e_run[MAXC], e_first[MAXC], e_last[MAXC];
   int e_pass[MAXC];

   conv_acc_sched #(.AW(AW), .SW(SW), .PW(PW), .DRAIN_CYC(DRAIN)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cfg_start_i(cfg_start), .cfg_abort_i(cfg_abort),
      .cfg_base_i(cfg_base), .cfg_size_i(cfg_size), .cfg_passes_i(cfg_passes),
      .cfg_fc_i(cfg_fc), .busy_o(busy), .done_o(done), .aborted_o(aborted),
      .acc_start_o(acc_start), .acc_base_o(acc_base), .acc_size_o(acc_size),
      .acc_fc_o(acc_fc), .acc_first_o(acc_first), .acc_last_o(acc_last),
      .acc_ready_i(acc_ready), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .pass_idx_o(pass_idx), .perf_stall_o(perf_stall));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);       chk({tag, "_done"}, done, 0);
      chk({tag, "_aborted"}, aborted, 0); chk({tag, "_acc_start"}, acc_start, 0);
      chk({tag, "_base"}, acc_base, 0);   chk({tag, "_size"}, acc_size, 0);
      chk({tag, "_fc"}, acc_fc, 0);       chk({tag, "_first"}, acc_first, 0);
      chk({tag, "_last"}, acc_last, 0);   chk({tag, "_pass_idx"}, pass_idx, 0);
      chk({tag, "_perf"}, perf_stall, 0); chk({tag, "_in_ready"}, in_ready, 0);
   endtask

   // mode 0: acc_ready always 1; 1: acc_ready low in cycles 10..12; 2: random.
   // ign_at: cycle in which a stray cfg_start with junk config is driven (-1 none).
   task automatic run_tile(input int sz, input int np, input int mode, input int ign_at,
                           output int done_at);
      logic [AW-1:0] base;
      logic          fc;
      int c, t, k, stalls, exp_done, n_acc;
      base = AW'($urandom);
      fc   = 1'($urandom);
      for (int i = 0; i < MAXC; i++) begin
         rdy[i] = (mode == 2) ? ($urandom_range(0, 3) != 0) : !(mode == 1 && i >= 10 && i <= 12);
         e_start[i] = 0; e_run[i] = 0; e_first[i] = 0; e_last[i] = 0; e_pass[i] = -1;
      end
      // Schedule model: a pass is launch, then cycles until sz ready cycles seen, then drain
      c = 1; stalls = 0;
      for (int p = 0; p < np; p++) begin
         e_start[c] = 1; k = 0; t = c + 1;
         while (k < sz && t < MAXC - 16) begin
            e_run[t] = 1;
            if (rdy[t]) k++; else stalls++;
            t++;
         end
         t += DRAIN;
         for (int i = c; i < t; i++) begin
            e_first[i] = (p == 0); e_last[i] = (p == np - 1); e_pass[i] = p;
         end
         c = t;
      end
      exp_done = c;
      @(negedge clk);
      cfg_start = 1; cfg_size = SW'(sz); cfg_passes = PW'(np); cfg_base = base; cfg_fc = fc;
      in_valid = 1; acc_ready = 1;
      @(negedge clk);
      done_at = -1; n_acc = 0;
      for (int tt = 1; tt <= exp_done + 1; tt++) begin
         acc_ready = rdy[tt];
         cfg_start = (tt == ign_at);
         if (tt == ign_at) begin
            cfg_size = SW'($urandom); cfg_passes = PW'($urandom); cfg_base = AW'($urandom);
         end
         #1;
         chk("acc_start", acc_start, e_start[tt]);
         chk("busy", busy, tt <= exp_done);
         chk("done", done, tt == exp_done);
         chk("aborted", aborted, 0);
         chk("in_ready", in_ready, e_run[tt] && rdy[tt]);
         chk("acc_first", acc_first, e_first[tt]);
         chk("acc_last", acc_last, e_last[tt]);
         if (e_pass[tt] >= 0) begin
            chk("pass_idx", pass_idx, e_pass[tt]);
            chk("acc_base", acc_base, base);
            chk("acc_size", acc_size, sz);
            chk("acc_fc", acc_fc, fc);
         end
         if (done === 1'b1) done_at = tt;
         if (in_valid && in_ready === 1'b1) n_acc++;
         @(negedge clk);
      end
      cfg_start = 0;
      chk("n_accepted", n_acc, sz * np);
`ifdef CONV_ACC_SCHED_PERF_EN
      chk("perf_stall", perf_stall, stalls);
`else
      chk("perf_stall", perf_stall, 0);
`endif
   endtask

   initial begin
      int d, seen;
      rst_n = 1; cfg_start = 0; cfg_abort = 0; cfg_fc = 0; acc_ready = 0; in_valid = 0;
      cfg_base = '0; cfg_size = '0; cfg_passes = '0;
      #3 rst_n = 0;
      #1 chk_all_zero("reset");
      @(negedge clk); rst_n = 1;

      // Basic run: size 4, 3 passes, no backpressure
      run_tile(4, 3, 0, -1, d);
      chk("basic_done_cycle", d, 22);

      // Backpressure in pass 1
      run_tile(4, 3, 1, -1, d);
      chk("bp_done_cycle", d, 25);

      // Degenerate configs
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         cfg_start = 1; cfg_size = (i == 0) ? SW'(0) : SW'(5); cfg_passes = (i == 0) ? PW'(3) : PW'(0);
         @(negedge clk); cfg_start = 0;
         #1 chk("degen_done", done, 1); chk("degen_busy", busy, 1); chk("degen_start", acc_start, 0);
         @(negedge clk);
         #1 chk("degen_done_end", done, 0); chk("degen_busy_end", busy, 0); chk("degen_start2", acc_start, 0);
      end

      // Abort in IDLE is ignored
      @(negedge clk); cfg_abort = 1;
      @(negedge clk); cfg_abort = 0;
      #1 chk("idle_abort", aborted, 0);

      // Abort during drain of pass 1 (cycle 13)
      @(negedge clk);
      cfg_start = 1; cfg_size = 4; cfg_passes = 3; acc_ready = 1; in_valid = 1;
      @(negedge clk); cfg_start = 0;
      repeat (12) @(negedge clk);
      cfg_abort = 1;
      #1 chk("abort_pre_busy", busy, 1); chk("abort_pre_pass", pass_idx, 1);
      @(negedge clk); cfg_abort = 0;
      #1 chk("abort_pulse", aborted, 1); chk("abort_busy", busy, 0);
      chk("abort_done", done, 0); chk("abort_start", acc_start, 0);
      @(negedge clk);
      #1 chk("abort_pulse_end", aborted, 0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         #1 if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("abort_quiet", seen, 0);
      run_tile(2, 1, 0, -1, d);
      chk("post_abort_done_cycle", d, 1 + 1 + 2 + DRAIN);

      // Stray start during RUN (cycle 4) is ignored
      run_tile(4, 3, 0, 4, d);
      chk("ign_done_cycle", d, 22);

      // Random backpressure tiles
      for (int r = 0; r < 4; r++) begin
         run_tile($urandom_range(1, 12), $urandom_range(1, 4), 2, (r == 1) ? 5 : -1, d);
      end

      // Reset mid-RUN
      @(negedge clk);
      cfg_start = 1; cfg_size = 6; cfg_passes = 2; acc_ready = 1; in_valid = 1;
      @(negedge clk); cfg_start = 0;
      repeat (3) @(negedge clk);
      #1 chk("pre_reset_busy", busy, 1);
      rst_n = 0;
      #1 chk_all_zero("mid_reset");
      @(negedge clk); rst_n = 1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         #1 if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("post_reset_quiet", seen, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/conv_acc_sched.md
Name: conv_acc_sched

Overview:
Sequencer for the conv_acc partial-sum accumulator. Runs one output tile as N channel passes.
- Each pass: issues the accumulator start, base, size and fc configuration, drives the first/last pass flags, and gates the PE result stream into the accumulator.
- Between passes it waits a fixed drain window so the accumulator write-back completes.
- Sits between the layer control registers and conv_acc.

Parameters:
AW, 8, accumulator RAM address width (acc_base, cfg_base)
SW, 11, element-count width (cfg_size, acc_size)
PW, 6, pass-count width (cfg_passes)
DRAIN_CYC, 3, cycles waited after the last element of a pass (legal range 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle launch request, sampled only in IDLE
cfg_abort  in  1  abort request, any state
cfg_base  in  AW  accumulator base address
cfg_size  in  SW  elements per pass
cfg_passes  in  PW  number of channel passes
cfg_fc  in  1  fully-connected mode, forwarded to accumulator
busy  out  1  high from LAUNCH through DONE
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort
acc_start  out  1  one-cycle pulse per pass
acc_base  out  AW  latched cfg_base
acc_size  out  SW  latched cfg_size
acc_fc  out  1  latched cfg_fc
acc_first  out  1  current pass is pass 0 (accumulator adds bias)
acc_last  out  1  current pass is the final pass (accumulator emits sum)
acc_ready  in  1  accumulator can take an element (m_ready)
in_valid  in  1  PE result element valid
in_ready  out  1  element accepted when in_valid & in_ready
pass_idx  out  PW  current pass number
perf_stall  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched config 0. Reset mid-operation discards the tile with no done and no aborted pulse.
- All outputs are registered except in_ready, which is combinational: (state==RUN) & acc_ready & (elem_cnt<size).
- States: IDLE, LAUNCH, RUN, DRAIN, DONE.
- IDLE:
  - cfg_start=1 with size!=0 and passes!=0: latch the configuration, set pass_idx=0, go to LAUNCH.
  - cfg_start=1 with size==0 or passes==0: go straight to DONE; acc_start never pulses.
  - cfg_start while busy is ignored.
- LAUNCH (1 cycle): acc_start=1, elem_cnt cleared, acc_first=(pass_idx==0), acc_last=(pass_idx==passes-1). Next state is RUN.
- acc_first and acc_last hold stable from LAUNCH through the end of that pass's DRAIN.
- RUN:
  - elem_cnt increments on each accepted element.
  - On the edge that accepts element number size, go to DRAIN and load drain_cnt=DRAIN_CYC-1.
  - in_valid=1 with acc_ready=0 is a stall and the state holds.
- DRAIN (exactly DRAIN_CYC cycles): when drain_cnt reaches 0, go to DONE if pass_idx==passes-1. Otherwise increment pass_idx and go to LAUNCH.
- DONE (1 cycle): done=1 and busy=1, then IDLE with busy=0.
- Abort: cfg_abort=1 in any non-IDLE state has priority over every other transition. On the next edge: state IDLE, aborted=1 for one cycle, busy=0, acc_start=0.
  - Abort in IDLE is ignored.
  - Abort coinciding with the DONE cycle: done is already high, so no aborted pulse.
- Widths: elem_cnt is SW bits and pass_idx is PW bits, with no wrap. Maximum legal values are size=2^SW-1 and passes=2^PW-1.
- Cycles per pass = 1 + size + stall cycles + DRAIN_CYC.

Optional Feature:
CONV_ACC_SCHED_PERF_EN
- Defined: perf_stall counts cycles with state==RUN & in_valid & !acc_ready. It clears on each accepted cfg_start, saturates at 2^32-1, and holds its value after done or abort.
- Undefined: the port remains and is tied to 0; no counter logic is built.

Test Plan:
- Basic run: DRAIN_CYC=2, size=4, passes=3, in_valid=1, acc_ready=1; cfg_start on cycle 0 puts LAUNCH in cycle 1.
  - Required: acc_start high in cycles 1, 8 and 15 only; acc_first=1 only in cycles 1-7; acc_last=1 only in cycles 15-21.
  - Required: done high in cycle 22 only, busy=0 from cycle 23; exactly 12 elements accepted.
- Backpressure: same setup with acc_ready=0 for 3 cycles during pass 1.
  - Required: done moves to cycle 25, in_ready=0 in those 3 cycles, perf_stall=3 with the macro defined and 0 without it.
- Degenerate config: size=0 or passes=0.
  - Required: no acc_start; done pulses in the cycle after cfg_start; busy high for that one cycle.
- Abort: cfg_abort during DRAIN of pass 1.
  - Required: next cycle state IDLE, aborted=1, busy=0, no done.
  - Required: a following cfg_start with passes=1, size=2 completes normally with acc_first=1 and acc_last=1.
- Ignored start and reset: cfg_start during RUN is ignored and pass_idx is unchanged; rst_n low mid-RUN clears all outputs to 0 immediately, with no done and no aborted pulse.
